instruction_decoder: RTL and testbench
======================================

// Module: instruction_decoder
// PURPOSE
//  Consumer end of the program-sequencer interface. Registers the fetched
//  instruction word (pm_data) into ir each clk and decodes it.
//  Drives the sequencer's jmp / jmp_nz / jmp_addr / dont_jmp / NOPC8 inputs,
//  and drives the datapath register load enables, source select and ALU controls.
//  Owns the zero flag that qualifies conditional jumps.
// PARAMETERS
//  FLUSH_CYCLES  1   cycles after reset release during which all decode outputs are forced inactive
//  CNT_W         16  width of the saturating retired-instruction counter
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      asynchronous, active-high reset
//  pm_data    in   8      instruction word read from program memory at pm_addr
//  alu_zero   in   1      ALU result == 0, valid during the ALU instruction's cycle
//  ir         out  8      instruction register
//  jmp        out  1      unconditional jump request
//  jmp_nz     out  1      conditional jump request (jump when zero flag clear)
//  jmp_addr   out  4      jump target nibble (sequencer appends 4'h0)
//  dont_jmp   out  1      registered zero flag (zf)
//  NOPC8      out  1      skip-next request (pm_addr = pc+2); see CONFIGURATION
//  reg_en     out  8      one-hot register load enable
//  src_sel    out  3      data-bus source select for a move
//  data_imm   out  4      immediate operand = ir[3:0]
//  alu_en     out  1      ALU instruction in ir
//  alu_y_sel  out  1      ALU second-operand select = ir[4]
//  alu_func   out  3      ALU function = ir[2:0]
//  retired    out  CNT_W  count of decoded (non-flush) instructions, saturating
// BEHAVIOUR
//  - Reset (async): ir=8'h00, zf=0, retired=0, FSM=FLUSH with flush counter = FLUSH_CYCLES.
//    All outputs read 0 while reset is high.
//  - ir <= pm_data on every clk edge, flush included. Decode is combinational from ir,
//    so there is zero latency from ir to the control outputs.
//  - FSM FLUSH: every control output = 0. The counter decrements each clk; at 0 the FSM moves to RUN.
//    FLUSH_CYCLES=0 enters RUN on the first edge after reset.
//  - FSM RUN: decode ir per the table below. Reset asserted mid-RUN forces FLUSH immediately.
//  - Decode table:
//      0ddd_iiii  load imm:  reg_en[ddd]=1, src_sel=3'b111 (immediate)
//      10dd_dsss  move:      reg_en[ddd]=1, src_sel=sss
//      110y_xfff  ALU:       alu_en=1, alu_y_sel=y, alu_func=fff
//      1110_aaaa  jmp:       jmp=1, jmp_addr=aaaa
//      1111_aaaa  jmp_nz:    jmp_nz=1, jmp_addr=aaaa
//  - jmp_addr = ir[3:0] only when jmp or jmp_nz is asserted; 0 otherwise. Unused outputs are 0.
//  - zf: zf <= alu_zero at the clk edge ending a RUN cycle with alu_en=1. zf holds otherwise.
//    dont_jmp = zf.
//  - An ALU op immediately followed by jmp_nz sees the updated zf; no bypass is needed.
//  - retired increments each RUN clk and saturates at all-ones (no wrap).
// CONFIGURATION
//  NOPC8_DETECT_EN defined:
//    - ir==8'hC8 in RUN asserts NOPC8=1 for that cycle.
//    - It is not treated as an ALU op: alu_en=0, zf unchanged.
//    - It counts as retired.
//  NOPC8_DETECT_EN undefined:
//    - NOPC8 is tied to 0.
//    - 8'hC8 decodes as ALU: y=0, func=3'b000.
// TESTING
//  1 reset high, pm_data=8'hE5, release; FLUSH_CYCLES=1 -> first edge all outputs 0;
//    next cycle jmp=1, jmp_addr=4'h5.
//  2 RUN, ir=8'h3A -> reg_en=8'b0000_1000, src_sel=3'b111, data_imm=4'hA, alu_en=0.
//  3 ir=8'hC3 with alu_zero=1, then ir=8'hF7 -> dont_jmp=1, jmp_nz=1, jmp_addr=4'h7.
//    Repeat with alu_zero=0 -> dont_jmp=0.
//  4 ir=8'h8D (move r1<-r5) -> reg_en=8'b0000_0010, src_sel=3'b101. zf unchanged from prior value.
//  5 ir=8'hC8 with alu_zero=1 -> NOPC8_DETECT_EN: NOPC8=1, alu_en=0, zf unchanged;
//    undefined: NOPC8=0, alu_en=1, zf<=1.
//  6 force retired to all-ones, clock in RUN -> stays all-ones;
//    assert reset mid-RUN -> retired=0 and all outputs 0 immediately, without waiting for clk.

Source files
------------

// File: rtl/instruction_decoder.sv
// instruction_decoder: latches pm_data into ir and decodes sequencer and datapath controls.
// Build option NOPC8_DETECT_EN: 8'hC8 becomes a skip-next request instead of an ALU op.
module instruction_decoder #(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       pm_data,
    input  logic             alu_zero,
    output logic [7:0]       ir,
    output logic             jmp,
    output logic             jmp_nz,
    output logic [3:0]       jmp_addr,
    output logic             dont_jmp,
    output logic             NOPC8,
    output logic [7:0]       reg_en,
    output logic [2:0]       src_sel,
    output logic [3:0]       data_imm,
    output logic             alu_en,
    output logic             alu_y_sel,
    output logic [2:0]       alu_func,
    output logic [CNT_W-1:0] retired
);

    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;

    typedef enum logic {
        FLUSH = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t          state;
    logic [FC_W-1:0] flush_cnt;
    logic            zf;

    logic is_imm;
    logic is_mov;
    logic is_alu;
    logic is_jmp;
    logic is_jnz;
    logic is_skip;
    logic run;

    assign run = (state == RUN);

`ifdef NOPC8_DETECT_EN
    assign is_skip = (ir == 8'hC8);
`else
    assign is_skip = 1'b0;
`endif

    assign is_imm = ~ir[7];
    assign is_mov = (ir[7:6] == 2'b10);
    assign is_alu = (ir[7:5] == 3'b110) && !is_skip;
    assign is_jmp = (ir[7:4] == 4'hE);
    assign is_jnz = (ir[7:4] == 4'hF);

    // Class predicates are mutually exclusive across all 256 codes
    always_comb begin
        jmp       = 1'b0;
        jmp_nz    = 1'b0;
        jmp_addr  = 4'h0;
        NOPC8     = 1'b0;
        reg_en    = 8'h00;
        src_sel   = 3'b000;
        data_imm  = 4'h0;
        alu_en    = 1'b0;
        alu_y_sel = 1'b0;
        alu_func  = 3'b000;
        if (run) begin
            unique case (1'b1)
                is_skip: begin
                    NOPC8 = 1'b1;
                end
                is_imm: begin
                    reg_en   = 8'h01 << ir[6:4];
                    src_sel  = 3'b111;
                    data_imm = ir[3:0];
                end
                is_mov: begin
                    reg_en  = 8'h01 << ir[5:3];
                    src_sel = ir[2:0];
                end
                is_alu: begin
                    alu_en    = 1'b1;
                    alu_y_sel = ir[4];
                    alu_func  = ir[2:0];
                end
                is_jmp: begin
                    jmp      = 1'b1;
                    jmp_addr = ir[3:0];
                end
                is_jnz: begin
                    jmp_nz   = 1'b1;
                    jmp_addr = ir[3:0];
                end
                default: begin
                end
            endcase
        end
    end

    assign dont_jmp = zf;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir <= 8'h00;
        end else begin
            ir <= pm_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= FLUSH;
            flush_cnt <= FC_W'(FLUSH_CYCLES);
        end else begin
            unique case (state)
                FLUSH: begin
                    if (flush_cnt == '0) begin
                        state <= RUN;
                    end else begin
                        flush_cnt <= flush_cnt - FC_W'(1);
                    end
                end
                RUN: begin
                    state <= RUN;
                end
                default: begin
                    state <= FLUSH;
                end
            endcase
        end
    end

    // zf captures the ALU result seen during the cycle the op sits in ir
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            zf <= 1'b0;
        end else if (run && alu_en) begin
            zf <= alu_zero;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retired <= '0;
        end else if (run && !(&retired)) begin
            retired <= retired + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_instruction_decoder.sv
// Directed testbench for instruction_decoder with a reference model and scoreboard.
module tb_instruction_decoder;

    localparam int CW = 4;

`ifdef NOPC8_DETECT_EN
    localparam bit SKIP_EN = 1'b1;
`else
    localparam bit SKIP_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    pm_data = 8'h00;
    logic          alu_zero = 1'b0;
    logic [7:0]    ir;
    logic          jmp;
    logic          jmp_nz;
    logic [3:0]    jmp_addr;
    logic          dont_jmp;
    logic          NOPC8;
    logic [7:0]    reg_en;
    logic [2:0]    src_sel;
    logic [3:0]    data_imm;
    logic          alu_en;
    logic          alu_y_sel;
    logic [2:0]    alu_func;
    logic [CW-1:0] retired;

    instruction_decoder #(
        .FLUSH_CYCLES(1),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .pm_data(pm_data),
        .alu_zero(alu_zero),
        .ir(ir),
        .jmp(jmp),
        .jmp_nz(jmp_nz),
        .jmp_addr(jmp_addr),
        .dont_jmp(dont_jmp),
        .NOPC8(NOPC8),
        .reg_en(reg_en),
        .src_sel(src_sel),
        .data_imm(data_imm),
        .alu_en(alu_en),
        .alu_y_sel(alu_y_sel),
        .alu_func(alu_func),
        .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]    ir;
        logic          jmp;
        logic          jmp_nz;
        logic [3:0]    jmp_addr;
        logic          dont_jmp;
        logic          nopc8;
        logic [7:0]    reg_en;
        logic [2:0]    src_sel;
        logic [3:0]    data_imm;
        logic          alu_en;
        logic          alu_y_sel;
        logic [2:0]    alu_func;
        logic [CW-1:0] retired;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    logic [7:0]    m_ir;
    logic          m_run;
    int            m_cnt;
    logic          m_zf;
    logic [CW-1:0] m_ret;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic m_is_alu(input logic [7:0] i);
        return (i[7:5] == 3'b110) && !(SKIP_EN && i == 8'hC8);
    endfunction

    function automatic exp_t predict();
        exp_t e;
        e = '0;
        e.ir = m_ir;
        e.dont_jmp = m_zf;
        e.retired = m_ret;
        if (m_run) begin
            if (!m_ir[7]) begin
                e.reg_en = 8'h01 << m_ir[6:4];
                e.src_sel = 3'b111;
                e.data_imm = m_ir[3:0];
            end else if (m_ir[7:6] == 2'b10) begin
                e.reg_en = 8'h01 << m_ir[5:3];
                e.src_sel = m_ir[2:0];
            end else if (m_ir[7:4] == 4'hE) begin
                e.jmp = 1'b1;
                e.jmp_addr = m_ir[3:0];
            end else if (m_ir[7:4] == 4'hF) begin
                e.jmp_nz = 1'b1;
                e.jmp_addr = m_ir[3:0];
            end else if (SKIP_EN && m_ir == 8'hC8) begin
                e.nopc8 = 1'b1;
            end else begin
                e.alu_en = 1'b1;
                e.alu_y_sel = m_ir[4];
                e.alu_func = m_ir[2:0];
            end
        end
        return e;
    endfunction

    task automatic model_reset();
        m_ir = 8'h00;
        m_run = 1'b0;
        m_cnt = 1;
        m_zf = 1'b0;
        m_ret = '0;
    endtask

    task automatic compare(input string tag);
        exp_t e;
        if (q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: observed empty scoreboard expected entry", tag);
            return;
        end
        e = q.pop_front();
        chk({tag, ".ir"}, 32'(ir), 32'(e.ir));
        chk({tag, ".jmp"}, 32'(jmp), 32'(e.jmp));
        chk({tag, ".jmp_nz"}, 32'(jmp_nz), 32'(e.jmp_nz));
        chk({tag, ".jmp_addr"}, 32'(jmp_addr), 32'(e.jmp_addr));
        chk({tag, ".dont_jmp"}, 32'(dont_jmp), 32'(e.dont_jmp));
        chk({tag, ".NOPC8"}, 32'(NOPC8), 32'(e.nopc8));
        chk({tag, ".reg_en"}, 32'(reg_en), 32'(e.reg_en));
        chk({tag, ".src_sel"}, 32'(src_sel), 32'(e.src_sel));
        chk({tag, ".data_imm"}, 32'(data_imm), 32'(e.data_imm));
        chk({tag, ".alu_en"}, 32'(alu_en), 32'(e.alu_en));
        chk({tag, ".alu_y_sel"}, 32'(alu_y_sel), 32'(e.alu_y_sel));
        chk({tag, ".alu_func"}, 32'(alu_func), 32'(e.alu_func));
        chk({tag, ".retired"}, 32'(retired), 32'(e.retired));
    endtask

    // Load pm, take one edge, set alu_zero for the new ir, compare on the falling edge
    task automatic cyc(input string tag, input logic [7:0] pm, input logic az);
        pm_data = pm;
        @(posedge clk);
        if (m_run) begin
            if (m_is_alu(m_ir)) m_zf = alu_zero;
            if (!(&m_ret)) m_ret = m_ret + 1'b1;
        end else if (m_cnt == 0) begin
            m_run = 1'b1;
        end else begin
            m_cnt--;
        end
        m_ir = pm;
        q.push_back(predict());
        #1;
        alu_zero = az;
        @(negedge clk);
        compare(tag);
    endtask

    initial begin
        model_reset();
        reset = 1'b1;
        pm_data = 8'hE5;
        #2;
        q.push_back(predict());
        compare("rst");
        @(negedge clk);
        reset = 1'b0;

        cyc("flush", 8'hE5, 1'b0);
        chk("flush_jmp", 32'(jmp), 32'd0);
        cyc("run_jmp", 8'hE5, 1'b0);
        chk("t1_jmp", 32'(jmp), 32'd1);
        chk("t1_addr", 32'(jmp_addr), 32'h5);

        cyc("imm", 8'h3A, 1'b0);
        chk("t2_reg_en", 32'(reg_en), 32'h08);
        chk("t2_src", 32'(src_sel), 32'h7);
        chk("t2_imm", 32'(data_imm), 32'hA);
        chk("t2_alu_en", 32'(alu_en), 32'd0);

        cyc("alu1", 8'hC3, 1'b1);
        cyc("jnz1", 8'hF7, 1'b0);
        chk("t3_zf1", 32'(dont_jmp), 32'd1);
        chk("t3_jnz", 32'(jmp_nz), 32'd1);
        chk("t3_addr", 32'(jmp_addr), 32'h7);
        cyc("alu0", 8'hC3, 1'b0);
        cyc("jnz0", 8'hF7, 1'b0);
        chk("t3_zf0", 32'(dont_jmp), 32'd0);

        cyc("mov", 8'h8D, 1'b1);
        chk("t4_reg_en", 32'(reg_en), 32'h02);
        chk("t4_src", 32'(src_sel), 32'h5);
        cyc("after_mov", 8'hE0, 1'b0);
        chk("t4_zf_hold", 32'(dont_jmp), 32'd0);

        cyc("c8", 8'hC8, 1'b1);
        chk("t5_nopc8", 32'(NOPC8), SKIP_EN ? 32'd1 : 32'd0);
        chk("t5_alu_en", 32'(alu_en), SKIP_EN ? 32'd0 : 32'd1);
        cyc("after_c8", 8'hF2, 1'b0);
        chk("t5_zf", 32'(dont_jmp), SKIP_EN ? 32'd0 : 32'd1);

        for (int i = 0; i < 16; i++) begin
            cyc("rand", 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        end
        chk("t6_sat", 32'(retired), 32'hF);
        cyc("sat_hold", 8'h11, 1'b0);
        chk("t6_sat_hold", 32'(retired), 32'hF);

        #2;
        reset = 1'b1;
        #1;
        chk("t6_rst_ret", 32'(retired), 32'd0);
        chk("t6_rst_reg_en", 32'(reg_en), 32'd0);
        chk("t6_rst_ir", 32'(ir), 32'd0);
        model_reset();
        q.push_back(predict());
        compare("midrst");
        @(negedge clk);
        reset = 1'b0;
        cyc("flush2", 8'h5C, 1'b0);
        cyc("run2", 8'h5C, 1'b0);
        chk("t6_reg_en", 32'(reg_en), 32'h20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
